oldland_muldiv: RTL and testbench
=================================

// Module: oldland_muldiv
//
// PURPOSE
//   Iterative integer multiply/divide unit alongside the execute stage's single-cycle ALU.
//   Accepts one operation per start pulse, computes over several cycles with busy held, then
//   pulses done with a double-width product or a quotient/remainder pair.
//   Execute stalls the pipeline on busy and writes back result_lo/result_hi on done.
//
// PARAMETERS
//   WIDTH           32  operand width in bits; result_lo/result_hi are WIDTH each
//   BITS_PER_CYCLE  1   bits retired per iteration (1, 2 or 4); must divide WIDTH
//
// PORTS
//   clk          in   1      clock, all state on rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   start        in   1      request; accepted only in IDLE with flush low
//   op           in   2      00 MULU, 01 MULS, 10 DIVU, 11 DIVS
//   a            in   WIDTH  multiplicand / dividend
//   b            in   WIDTH  multiplier / divisor
//   flush        in   1      abandon operation in flight (exception/branch kill)
//   busy         out  1      operation in flight; start ignored while high
//   done         out  1      one-cycle pulse: results valid
//   result_lo    out  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient
//   result_hi    out  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
//   div_by_zero  out  1      set with done when a DIV had b == 0; cleared on next accept
//
// BEHAVIOUR
//   - Reset (rst_n low, async): state IDLE; busy, done, div_by_zero = 0; result_lo/hi = 0.
//   - States: IDLE, RUN, FIXUP, DONE.  N = WIDTH/BITS_PER_CYCLE.
//   - IDLE: start & !flush -> latch op, a, b (later input changes ignored) -> RUN, iter count = N.
//     DIV with b == 0 instead -> DONE directly; result_lo = all ones, result_hi = a, div_by_zero = 1.
//   - RUN: MUL shift-add / DIV restoring, on operand magnitudes (signed ops take |a|, |b|);
//     BITS_PER_CYCLE steps per cycle; after N cycles -> FIXUP.
//   - FIXUP: one cycle of sign correction. MULS: negate 2*WIDTH product if sign(a)^sign(b).
//     DIVS: negate quotient if sign(a)^sign(b); remainder takes sign of a. -> DONE.
//   - DONE: done = 1 for exactly one cycle, -> IDLE. Same-cycle start is not accepted.
//   - Latency: accept in cycle 0 -> busy high cycles 1..N+1, done in cycle N+2; busy low with done.
//     Div-by-zero: busy never rises, done in cycle 1.
//   - Results registered; written only on entry to DONE; held until next DONE (not cleared by accept).
//   - Arithmetic modulo 2^WIDTH per half. DIVS MIN/-1: quotient = MIN, remainder = 0, no flag.
//     MULS with MIN operand: correct 2*WIDTH signed product (magnitude uses WIDTH+1 bits internally).
//   - flush: from any state -> IDLE next edge; busy = 0, done suppressed, results and div_by_zero
//     unchanged. flush & start in same cycle: flush wins, start dropped.
//   - start while busy or in DONE: ignored, no queuing.
//   - Reset mid-operation: immediate return to reset values, operation lost.
//
// TESTING  (WIDTH=32, BITS_PER_CYCLE=1 unless noted; cycle 0 = accept)
//   1. MULU a=0xFFFFFFFF b=0xFFFFFFFF -> done cycle 34, hi=0xFFFFFFFE lo=0x00000001, busy 1..33.
//   2. MULS a=-3 b=7 -> lo=0xFFFFFFEB hi=0xFFFFFFFF; MULS a=0x80000000 b=0x80000000
//      -> hi=0x40000000 lo=0.
//   3. DIVS a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVS 0x80000000/-1 -> lo=0x80000000 hi=0,
//      div_by_zero=0.
//   4. DIVU a=0x1234 b=0 -> done cycle 1, busy never high, lo=0xFFFFFFFF hi=0x1234, div_by_zero=1;
//      next MULU 2*3 clears flag, lo=6.
//   5. MULU started, flush cycle 10 -> busy 0 cycle 11, no done; start cycle 11 DIVU 100/7
//      -> done cycle 45, lo=14 hi=2; start pulses cycles 12..44 ignored.
//   6. BITS_PER_CYCLE=4: MULU 0x12345678*0x10 -> done cycle 10, lo=0x23456780 hi=0x1;
//      rst_n low cycle 5 -> all outputs 0, no done.

Source files
------------

// File: rtl/oldland_muldiv.sv
// Iterative multiply/divide unit beside the execute-stage ALU.
// Shift-add multiply and restoring divide on magnitudes, sign fixed up at the end.
module oldland_muldiv #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // op[1] selects divide, op[0] selects signed
    logic             accept;
    logic             div_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic             div_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] shr_q;
    logic [WIDTH-1:0] opd_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0]   acc_n;
    logic [WIDTH-1:0]   shr_n;
    logic [WIDTH:0]     rem_t;
    logic [WIDTH:0]     sum_t;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept   = (state == S_IDLE) && start && !flush;
    assign div_zero = op[1] && (b == '0);
    assign a_mag    = (op[0] && a[WIDTH-1]) ? -a : a;
    assign b_mag    = (op[0] && b[WIDTH-1]) ? -b : b;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = div_zero ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt_q == CW'(1)) begin
                        state_nxt = S_FIXUP;
                    end
                end
                S_FIXUP: state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from state; a flushed DONE never signals
    always_comb begin
        busy = (state == S_RUN) || (state == S_FIXUP);
        done = (state == S_DONE) && !flush;
    end

    // BITS_PER_CYCLE iterations of shift-add or restoring-divide
    always_comb begin
        acc_n = acc_q;
        shr_n = shr_q;
        rem_t = '0;
        sum_t = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (div_q) begin
                rem_t = {acc_n, shr_n[WIDTH-1]};
                shr_n = {shr_n[WIDTH-2:0], 1'b0};
                if (rem_t >= {1'b0, opd_q}) begin
                    rem_t    = rem_t - {1'b0, opd_q};
                    shr_n[0] = 1'b1;
                end
                acc_n = rem_t[WIDTH-1:0];
            end else begin
                sum_t = {1'b0, acc_n};
                if (shr_n[0]) begin
                    sum_t = sum_t + {1'b0, opd_q};
                end
                {acc_n, shr_n} = {sum_t, shr_n[WIDTH-1:1]};
            end
        end
    end

    // Sign correction applied while in FIXUP
    always_comb begin
        prod_fix = {acc_q, shr_q};
        quo_fix  = shr_q;
        rem_fix  = acc_q;
        if (neg_a_q ^ neg_b_q) begin
            prod_fix = -{acc_q, shr_q};
            quo_fix  = -shr_q;
        end
        if (neg_a_q) begin
            rem_fix = -acc_q;
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            acc_q   <= '0;
            shr_q   <= '0;
            opd_q   <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            div_q   <= op[1];
            neg_a_q <= op[0] && a[WIDTH-1];
            neg_b_q <= op[0] && b[WIDTH-1];
            acc_q   <= '0;
            shr_q   <= op[1] ? a_mag : b_mag;
            opd_q   <= op[1] ? b_mag : a_mag;
            cnt_q   <= CW'(N);
        end else if (state == S_RUN && !flush) begin
            acc_q <= acc_n;
            shr_q <= shr_n;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Result registers, loaded only on the way into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_by_zero <= div_zero;
            if (div_zero) begin
                result_lo <= '1;
                result_hi <= a;
            end
        end else if (state == S_FIXUP && !flush) begin
            if (div_q) begin
                result_lo <= quo_fix;
                result_hi <= rem_fix;
            end else begin
                result_lo <= prod_fix[WIDTH-1:0];
                result_hi <= prod_fix[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_oldland_muldiv.sv
// Bench for oldland_muldiv: directed cases plus random ops on
// 1-bit and 4-bit-per-cycle instances against an arithmetic model.
module tb_oldland_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1;
    logic        start4;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;

    logic        busy1, done1, dz1;
    logic [31:0] lo1, hi1;
    logic        busy4, done4, dz4;
    logic [31:0] lo4, hi4;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] last_lo;
    logic [31:0] last_hi;
    logic        last_dz;

    always #5 clk = ~clk;

    oldland_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op),
        .a(a), .b(b), .flush(flush), .busy(busy1), .done(done1),
        .result_lo(lo1), .result_hi(hi1), .div_by_zero(dz1)
    );

    oldland_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op),
        .a(a), .b(b), .flush(flush), .busy(busy4), .done(done4),
        .result_lo(lo4), .result_hi(hi4), .div_by_zero(dz4)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic dz);
        logic [63:0] p;
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        if (o[1] && y == 32'd0) begin
            p  = {x, 32'hFFFF_FFFF};
            dz = 1'b1;
        end else begin
            case (o)
                2'd0:    p = {32'd0, x} * {32'd0, y};
                2'd1:    p = 64'(sx * sy);
                2'd2:    p = {x % y, x / y};
                default: p = {32'(sx % sy), 32'(sx / sy)};
            endcase
        end
        lo = p[31:0];
        hi = p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // w = 0 selects the 1-bit instance, w = 1 the 4-bit instance
    task automatic run(input int w, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y);
        logic [31:0] elo, ehi;
        logic        edz;
        int          lat, cyc, bcnt;
        model(o, x, y, elo, ehi, edz);
        lat = (o[1] && y == 32'd0) ? 1 : (w != 0 ? 10 : 34);
        @(negedge clk);
        op = o; a = x; b = y;
        if (w != 0) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        cyc = 1; bcnt = 0;
        while (cyc <= 60) begin
            if ((w != 0) ? done4 : done1) break;
            if ((w != 0) ? busy4 : busy1) bcnt++;
            if (w != 0) start4 = 1'($urandom_range(0, 1));
            else        start1 = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom; op = 2'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(lat));
        chk("busy_cycles", 64'(bcnt), 64'(lat - 1));
        chk("busy_at_done", 64'((w != 0) ? busy4 : busy1), 64'd0);
        chk("lo", 64'((w != 0) ? lo4 : lo1), 64'(elo));
        chk("hi", 64'((w != 0) ? hi4 : hi1), 64'(ehi));
        chk("dz", 64'((w != 0) ? dz4 : dz1), 64'(edz));
        if (w == 0) begin
            last_lo = elo; last_hi = ehi; last_dz = edz;
        end
        if (w != 0) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        chk("start_in_done_busy", 64'((w != 0) ? busy4 : busy1), 64'd0);
        chk("start_in_done_done", 64'((w != 0) ? done4 : done1), 64'd0);
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
        op = 2'd0; a = '0; b = '0; flush = 1'b0;
        last_lo = '0; last_hi = '0; last_dz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'({busy1, busy4}), 64'd0);
        chk("rst_done", 64'({done1, done4}), 64'd0);
        chk("rst_res", {lo1, hi1} | {lo4, hi4}, 64'd0);
        chk("rst_dz", 64'({dz1, dz4}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(0, 2'd1, -32'sd3, 32'd7);
        run(0, 2'd1, 32'h8000_0000, 32'h8000_0000);
        run(0, 2'd3, -32'sd7, 32'd2);
        run(0, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run(0, 2'd2, 32'h1234, 32'd0);
        run(0, 2'd0, 32'd2, 32'd3);

        // flush mid-multiply
        @(negedge clk);
        op = 2'd0; a = $urandom; b = $urandom; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy1), 64'd0);
        chk("flush_done", 64'(done1), 64'd0);
        chk("flush_keep", {lo1, hi1}, {last_lo, last_hi});
        chk("flush_keep_dz", 64'(dz1), 64'(last_dz));
        run(0, 2'd2, 32'd100, 32'd7);

        // flush and start together: start dropped
        @(negedge clk);
        op = 2'd0; start1 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 64'(busy1), 64'd0);
        @(posedge clk); #1;
        chk("flush_start_done", 64'(done1), 64'd0);

        run(1, 2'd0, 32'h1234_5678, 32'h10);
        run(1, 2'd3, -32'sd7, 32'd2);

        // reset in the middle of an operation
        @(negedge clk);
        op = 2'd0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy4), 64'd0);
        chk("mid_rst_res4", {lo4, hi4}, 64'd0);
        chk("mid_rst_res1", {lo1, hi1}, 64'd0);
        chk("mid_rst_dz", 64'({dz1, dz4}), 64'd0);
        last_lo = '0; last_hi = '0; last_dz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done4) dcnt++;
        end
        chk("mid_rst_no_done", 64'(dcnt), 64'd0);

        for (int i = 0; i < 40; i++) begin
            run(i % 2, 2'($urandom), pick(), pick());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
